// File: rtl/sram_arbiter.sv
// +----------------------------------------------------------------------------+
// | sram_arbiter: two-master round-robin arbiter sequencing one APB transfer   |
// | at a time onto the shared on-chip SRAM, with an optional slave timeout.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      m0_req,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic                      m0_write,
  input  logic [DATA_WIDTH/8-1:0]   m0_stb,
  output logic                      m0_done,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic                      m1_write,
  input  logic [DATA_WIDTH/8-1:0]   m1_stb,
  output logic                      m1_done,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      m1_err,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pdata,
  output logic                      pwrite,
  output logic [DATA_WIDTH/8-1:0]   pstb,
  output logic                      psel,
  output logic                      penable,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      perr
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_SETUP    = 2'd1;
  localparam logic [1:0]       c_ACCESS   = 2'd2;
  localparam logic             c_TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]            r_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_pwrite;
  logic [SW-1:0]         r_pstb;

  logic                  w_any_req;
  logic                  w_pick;
  logic                  w_abort;
  logic                  w_finish;
  logic                  w_err;

  // Contention goes to the master that was not served last; otherwise the sole requester.
  assign w_any_req = m0_req | m1_req;
  assign w_pick    = (m0_req & m1_req) ? ~r_last_grant : m1_req;

  assign w_abort  = (r_state == c_ACCESS) & ~pready & c_TO_EN & (r_cnt == c_CNT_LAST);
  assign w_finish = (r_state == c_ACCESS) & (pready | w_abort);
  assign w_err    = pready ? perr : 1'b1;

  assign m0_done  = w_finish & ~r_grant;
  assign m1_done  = w_finish & r_grant;
  assign m0_rdata = m0_done ? prdata : '0;
  assign m1_rdata = m1_done ? prdata : '0;
  assign m0_err   = m0_done & w_err;
  assign m1_err   = m1_done & w_err;

  assign psel    = (r_state == c_SETUP) | (r_state == c_ACCESS);
  assign penable = (r_state == c_ACCESS);
  assign paddr   = r_paddr;
  assign pdata   = r_pdata;
  assign pwrite  = r_pwrite;
  assign pstb    = r_pstb;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state      <= c_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_paddr      <= '0;
      r_pdata      <= '0;
      r_pwrite     <= 1'b0;
      r_pstb       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_paddr      <= w_pick ? m1_addr  : m0_addr;
            r_pdata      <= w_pick ? m1_wdata : m0_wdata;
            r_pwrite     <= w_pick ? m1_write : m0_write;
            r_pstb       <= w_pick ? m1_stb   : m0_stb;
            r_state      <= c_SETUP;
          end
        end
        c_SETUP: begin
          r_cnt   <= '0;
          r_state <= c_ACCESS;
        end
        c_ACCESS: begin
          if (w_finish) begin
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_sram_arbiter: directed bench for sram_arbiter with a one-wait-state     |
// | APB SRAM stub whose read data is masked by pstb.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sram_arbiter;

  logic        pclk;
  logic        presetn;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_write, m1_write;
  logic [3:0]  m0_stb, m1_stb;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] paddr, pdata, prdata;
  logic        pwrite, psel, penable, pready, perr;
  logic [3:0]  pstb;

  logic        r_acc_seen;
  logic        ready_en;
  logic [31:0] mem [0:15];
  logic [31:0] w_mask;

  int errors = 0;
  int checks = 0;
  int w;

  sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_stb(m0_stb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_stb(m1_stb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .perr(perr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // SRAM stub: pready on the second ACCESS cycle, byte-masked reads and writes
  assign w_mask = {{8{pstb[3]}}, {8{pstb[2]}}, {8{pstb[1]}}, {8{pstb[0]}}};
  assign prdata = mem[paddr[5:2]] & w_mask;
  assign pready = psel & penable & r_acc_seen & ready_en;

  always @(posedge pclk) begin
    if (!presetn) begin
      r_acc_seen <= 1'b0;
      mem[4]     <= 32'hDEADBEEF;
      mem[8]     <= 32'hAAAAAAAA;
    end else begin
      r_acc_seen <= psel & penable & ~pready;
      if (psel & penable & pready & pwrite)
        mem[paddr[5:2]] <= (mem[paddr[5:2]] & ~w_mask) | (pdata & w_mask);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    presetn = 1'b0; ready_en = 1'b1; perr = 1'b0;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_write = 0; m0_stb = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_write = 0; m1_stb = 0;
    cyc(2);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pdata", pdata, 32'h0);
    chk("rst_pstb", pstb, 4'h0);
    chk("rst_done", {m1_done, m0_done}, 2'b00);

    // 1: uncontended M0 read
    presetn = 1'b1;
    m0_req = 1; m0_addr = 32'h10; m0_stb = 4'hF; m0_write = 0;
    cyc(1);
    chk("t1_c1_psel", {psel, penable}, 2'b10);
    chk("t1_c1_paddr", paddr, 32'h10);
    cyc(1);
    chk("t1_c2_pen", {psel, penable}, 2'b11);
    chk("t1_c2_done", m0_done, 1'b0);
    cyc(1);
    chk("t1_c3_done", {m1_done, m0_done}, 2'b01);
    chk("t1_c3_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_c3_err", m0_err, 1'b0);
    m0_req = 0;
    cyc(1);
    chk("t1_c4_idle", {psel, penable, m0_done}, 3'b000);

    // 2: simultaneous requests after reset
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m0_stb = 4'hF; m0_write = 0;
    m1_req = 1; m1_addr = 32'h20; m1_stb = 4'hF; m1_write = 0;
    cyc(3);
    chk("t2_c3_done", {m1_done, m0_done}, 2'b01);
    chk("t2_c3_rdata", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    cyc(1);
    chk("t2_c4_hold", {psel, paddr}, {1'b0, 32'h10});
    cyc(1);
    chk("t2_c5_paddr", {psel, paddr}, {1'b1, 32'h20});
    cyc(1);
    chk("t2_c6_done", {m1_done, m0_done}, 2'b00);
    cyc(1);
    chk("t2_c7_done", {m1_done, m0_done}, 2'b10);
    chk("t2_c7_rdata", m1_rdata, 32'hAAAAAAAA);
    chk("t2_c7_m0zero", {m0_rdata, m0_err}, 33'h0);
    m1_req = 0;
    cyc(1);

    // 3: M1 partial write, inputs changed after grant, then M0 read-back
    m1_req = 1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_stb = 4'h3; m1_write = 1;
    cyc(1);
    m1_addr = 32'h3C; m1_wdata = 32'hFFFFFFFF; m1_stb = 4'hF; m1_write = 0;
    cyc(1);
    chk("t3_latched", {paddr, pdata, pstb, pwrite}, {32'h20, 32'h11223344, 4'h3, 1'b1});
    cyc(1);
    chk("t3_wr_done", {m1_done, m1_err}, 2'b10);
    m1_req = 0;
    cyc(1);
    m0_req = 1; m0_addr = 32'h20; m0_stb = 4'hF; m0_write = 0;
    cyc(3);
    chk("t3_rd_done", m0_done, 1'b1);
    chk("t3_rd_data", m0_rdata, 32'hAAAA3344);
    m0_req = 0;

    // 4: both requests held for 8 transfers
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m0_stb = 4'hF; m0_write = 0;
    m1_req = 1; m1_addr = 32'h20; m1_stb = 4'hF; m1_write = 0;
    for (int i = 0; i < 8; i++) begin
      w = 0;
      do begin
        @(negedge pclk);
        w++;
      end while (!(m0_done | m1_done) && w < 10);
      chk("t4_spacing", w, (i == 0) ? 3 : 4);
      chk("t4_grant", {m1_done, m0_done}, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    m0_req = 0; m1_req = 0;
    cyc(1);

    // 5: slave never ready -> abort on 16th ACCESS cycle, then M1 served
    ready_en = 0;
    m0_req = 1; m1_req = 1;
    cyc(16);
    chk("t5_c16_nodone", {m1_done, m0_done}, 2'b00);
    cyc(1);
    chk("t5_c17_abort", {m1_done, m0_done, m0_err, psel}, 4'b0111);
    m0_req = 0;
    cyc(1);
    chk("t5_c18_idle", psel, 1'b0);
    ready_en = 1; perr = 1;
    cyc(1);
    chk("t5_c19_m1", {psel, paddr}, {1'b1, 32'h20});
    cyc(2);
    chk("t5_c21_perr", {m1_done, m1_err}, 2'b11);
    m1_req = 0; perr = 0;
    cyc(1);

    // 6: reset during M1 ACCESS
    m1_req = 1; m1_addr = 32'h20;
    cyc(2);
    chk("t6_c2_access", {psel, penable}, 2'b11);
    presetn = 0;
    cyc(1);
    chk("t6_c3_reset", {psel, penable, m1_done}, 3'b000);
    presetn = 1;
    m0_req = 1; m0_addr = 32'h10; m0_stb = 4'hF; m0_write = 0;
    cyc(1);
    chk("t6_c4_m0first", {psel, paddr}, {1'b1, 32'h10});
    cyc(2);
    chk("t6_c6_m0done", {m1_done, m0_done}, 2'b01);
    chk("t6_c6_rdata", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    cyc(4);
    chk("t6_c10_m1done", {m1_done, m0_done}, 2'b10);
    chk("t6_c10_rdata", m1_rdata, 32'hAAAAAAAA);
    m1_req = 0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
